// File: rtl/regfile_writeback_pkg.sv
// regfile_writeback_pkg: shared widths, defaults and buffer entry type for the writeback slice
package regfile_writeback_pkg;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int NREG = 32;
  localparam int TW = 5;
  localparam int LQ_DEPTH_DEF = 4;
  typedef struct packed {
    logic [TW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: ALU/load/memory/decode/regfile signals; master = requesters, slave = writeback owner; REGFILE_WB_BYPASS_EN adds forwarding outputs
interface regfile_writeback_if;
  import regfile_writeback_pkg::*;
  logic alu_valid, alu_ready;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic ld_issue, ld_ready;
  logic [AW-1:0] ld_issue_addr;
  logic mem_valid;
  logic [DW-1:0] mem_data;
  logic [AW-1:0] rs1_addr, rs2_addr;
  logic rs1_busy, rs2_busy;
  logic write_reg;
  logic [AW-1:0] dstreg_addr;
  logic [DW-1:0] dstreg_data;
  logic ld_err;
`ifdef REGFILE_WB_BYPASS_EN
  logic rs1_fwd, rs2_fwd;
  logic [DW-1:0] fwd_data;
`endif
  modport master (
    output alu_valid, alu_addr, alu_data, ld_issue, ld_issue_addr, mem_valid, mem_data, rs1_addr, rs2_addr,
`ifdef REGFILE_WB_BYPASS_EN
    input rs1_fwd, rs2_fwd, fwd_data,
`endif
    input alu_ready, ld_ready, rs1_busy, rs2_busy, write_reg, dstreg_addr, dstreg_data, ld_err
  );
  modport slave (
    input alu_valid, alu_addr, alu_data, ld_issue, ld_issue_addr, mem_valid, mem_data, rs1_addr, rs2_addr,
`ifdef REGFILE_WB_BYPASS_EN
    output rs1_fwd, rs2_fwd, fwd_data,
`endif
    output alu_ready, ld_ready, rs1_busy, rs2_busy, write_reg, dstreg_addr, dstreg_data, ld_err
  );
endinterface

// File: rtl/regfile_writeback_tag_fifo.sv
// wb_tag_fifo: sync FIFO of 5-bit load tags; ports clk, rst, push_i/din_i, pop_i/dout_o, full_o, empty_o
module wb_tag_fifo
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = LQ_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [TW-1:0] din_i,
  output logic [TW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int PW = $clog2(DEPTH);
  logic [PW:0] wr_q, rd_q;
  logic [TW-1:0] mem_q [DEPTH];
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign dout_o = mem_q[rd_q[PW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
    end
  end
  always_ff @(posedge clk) if (push_i) mem_q[wr_q[PW-1:0]] <= din_i;
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU results and in-order load returns into one registered regfile write stream with a pending-load scoreboard; ports clk, rst, wb (slave); REGFILE_WB_BYPASS_EN adds rs1_fwd/rs2_fwd/fwd_data
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int LQ_DEPTH = LQ_DEPTH_DEF,
  parameter int ALU_BUF = 2
) (
  input logic clk,
  input logic rst,
  regfile_writeback_if.slave wb
);
  logic [NREG-1:0] busy_q, busy_d;
  wb_entry_t buf_q [2];
  logic [1:0] cnt_q, cnt_d, pos;
  logic write_q, write_d, err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic tag_full, tag_empty, tag_pop, ld_acc, alu_acc, buf_pop, buf_push, take;
  logic [TW-1:0] tag_head;
  wb_entry_t alu_in, sel;
  logic unused_ok;
  assign unused_ok = ^{wb.alu_addr[5], wb.ld_issue_addr[5], wb.rs1_addr[5], wb.rs2_addr[5]};
  wb_tag_fifo #(.DEPTH(LQ_DEPTH)) u_tags (
    .clk(clk),
    .rst(rst),
    .push_i(ld_acc),
    .pop_i(tag_pop),
    .din_i(wb.ld_issue_addr[4:0]),
    .dout_o(tag_head),
    .full_o(tag_full),
    .empty_o(tag_empty)
  );
  assign wb.alu_ready = (cnt_q != 2'(ALU_BUF)) && !busy_q[wb.alu_addr[4:0]];
  assign wb.ld_ready = !tag_full && !busy_q[wb.ld_issue_addr[4:0]];
  assign wb.rs1_busy = busy_q[wb.rs1_addr[4:0]];
  assign wb.rs2_busy = busy_q[wb.rs2_addr[4:0]];
  assign wb.write_reg = write_q;
  assign wb.dstreg_addr = addr_q;
  assign wb.dstreg_data = data_q;
  assign wb.ld_err = err_q;
`ifdef REGFILE_WB_BYPASS_EN
  assign wb.rs1_fwd = write_q && addr_q == wb.rs1_addr && wb.rs1_addr != '0;
  assign wb.rs2_fwd = write_q && addr_q == wb.rs2_addr && wb.rs2_addr != '0;
  assign wb.fwd_data = data_q;
`endif
  // Memory returns cannot stall, so they always take the write port; the ALU
  // path only bypasses the buffer when nothing older is waiting.
  always_comb begin
    alu_acc = wb.alu_valid && wb.alu_ready;
    ld_acc = wb.ld_issue && wb.ld_ready;
    tag_pop = wb.mem_valid && !tag_empty;
    buf_pop = !wb.mem_valid && cnt_q != 2'd0;
    buf_push = alu_acc && (wb.mem_valid || cnt_q != 2'd0);
    take = tag_pop || buf_pop || (alu_acc && !buf_push);
    alu_in = wb_entry_t'{wb.alu_addr[4:0], wb.alu_data};
    sel = tag_pop ? wb_entry_t'{tag_head, wb.mem_data} : buf_pop ? buf_q[0] : alu_in;
    write_d = take && sel.addr != '0;
    addr_d = take ? {1'b0, sel.addr} : addr_q;
    data_d = take ? sel.data : data_q;
    err_d = err_q || (wb.mem_valid && tag_empty);
    cnt_d = cnt_q + {1'b0, buf_push} - {1'b0, buf_pop};
    pos = cnt_q - {1'b0, buf_pop};
    busy_d = (busy_q & ~(tag_pop ? NREG'(1) << tag_head : '0))
           | (ld_acc && wb.ld_issue_addr[4:0] != '0 ? NREG'(1) << wb.ld_issue_addr[4:0] : '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q <= '0;
      write_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q <= cnt_d;
      write_q <= write_d;
      addr_q <= addr_d;
      data_q <= data_d;
      err_q <= err_d;
    end
  end
  // Shift-register FIFO: head is always slot 0; a push lands behind whatever survives the pop.
  always_ff @(posedge clk) begin
    if (buf_pop) buf_q[0] <= buf_q[1];
    if (buf_push) buf_q[pos[0]] <= alu_in;
  end
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Owner of the register-file write port. Merges single-cycle ALU results and out-of-order-latency load returns into one registered write stream (`write_reg`/`dstreg_addr`/`dstreg_data`) feeding `regfile`. Keeps a per-register pending-load scoreboard that decode queries to stall dependent instructions.

## Interface
- `LQ_DEPTH`, 4: outstanding-load tag queue depth (power of two, ≥2)
- `ALU_BUF`, 2: ALU result buffer depth (fixed at 2)
- `clk` input 1: sole clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `alu_valid` input 1: ALU result offered
- `alu_ready` output 1: ALU result accepted when `alu_valid & alu_ready`
- `alu_addr` input 6: destination register (bit 5 ignored)
- `alu_data` input 32: result
- `ld_issue` input 1: decode issues a load
- `ld_ready` output 1: load issue accepted when `ld_issue & ld_ready`
- `ld_issue_addr` input 6: load destination
- `mem_valid` input 1: load data returns, strictly in issue order; cannot be stalled
- `mem_data` input 32: load data
- `rs1_addr`, `rs2_addr` input 6: decode source operands
- `rs1_busy`, `rs2_busy` output 1: source has a pending load (combinational)
- `write_reg` output 1: regfile write enable
- `dstreg_addr` output 6: write address, bit 5 always 0
- `dstreg_data` output 32: write data
- `ld_err` output 1: sticky, `mem_valid` with empty tag queue

## Operation
- Reset: `write_reg`=0, `dstreg_addr`=0, `dstreg_data`=0, `ld_err`=0, tag queue and ALU buffer empty, all busy bits 0.
- Scoreboard: 32 busy bits. Accepted `ld_issue` pushes `ld_issue_addr[4:0]` into tag queue and sets busy bit. Busy bit clears on the cycle the matching write is driven on `write_reg`.
- `ld_ready` = tag queue not full AND busy[`ld_issue_addr`]=0 (one pending load per register).
- `alu_ready` = ALU buffer not full AND busy[`alu_addr`]=0 (no WAW over a pending load).
- Output arbitration per cycle: `mem_valid` wins (pops tag queue head, writes `mem_data`); else oldest ALU buffer entry; else `write_reg`=0.
- An accepted ALU result goes straight to the output register if the buffer is empty and no `mem_valid`; otherwise it is buffered FIFO.
- Address 0: writes to register 0 are accepted and consumed but drive `write_reg`=0. A load to register 0 does not set a busy bit.
- `mem_valid` with empty tag queue: data dropped, `ld_err` set until reset.
- Simultaneous accepted ALU input and buffer pop: both occur; occupancy unchanged.
- Simultaneous push and pop on a full tag queue: `ld_ready` stays low (full is evaluated before pop).

## Timing
- ALU result accepted in cycle N with empty buffer and no `mem_valid` → `write_reg` high in N+1.
- `mem_valid` in cycle N → `write_reg` high in N+1 with the head tag address; busy bit low from N+1.
- Busy bit set by `ld_issue` in N is visible on `rsX_busy` from N+1.
- Reset mid-operation: all pending loads and buffered ALU results discarded; later returns of pre-reset loads set `ld_err`.

## Configuration
- `REGFILE_WB_BYPASS_EN` defined: adds outputs `rs1_fwd`, `rs2_fwd` (1 bit) and `fwd_data` (32 bits); `rsX_fwd` asserts when `write_reg` is high and `dstreg_addr` equals `rsX_addr` (nonzero), and `fwd_data`=`dstreg_data`. Decode uses it to avoid the regfile's same-cycle stale read.
- Not defined: ports absent; decode must wait one extra cycle after the busy bit drops.

## Structure
- Shared package: register-address width (6), data width (32), register count (32), `LQ_DEPTH` default.
- One sub-module, `wb_tag_fifo`: synchronous FIFO of 5-bit tags with full/empty, used for the tag queue; the ALU buffer is a small in-line 2-entry FIFO.

## Test plan
- ALU write r5=0x1234 in cycle 1, idle memory → `write_reg`=1, `dstreg_addr`=5, `dstreg_data`=0x1234 in cycle 2.
- Load to r7, then `mem_valid` with 0xDEAD 3 cycles later → `rs1_busy` high for `rs1_addr`=7 from issue+1 until the write, write r7=0xDEAD, busy clears.
- `mem_valid` and `alu_valid` (r3=0x11) same cycle → load written first, r3 written next cycle, `alu_ready` stays high.
- Issue 4 loads (r1–r4), 5th issue → `ld_ready`=0; returns write r1..r4 in order; `ld_issue` to pending r2 → `ld_ready`=0.
- `mem_valid` after reset with no load issued → no write, `ld_err`=1 and stays 1 until `rst`.
- ALU write to r0 → accepted, `write_reg` stays 0; with `REGFILE_WB_BYPASS_EN`, write r9 while `rs2_addr`=9 → `rs2_fwd`=1, `fwd_data` matches.
